// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and forwarding controller for the ARM pipeline. It tracks every
// in-flight destination from EXE through WB in a shift-register scoreboard,
// raises freeze/flush for the front end, and picks a forwarding source for
// each EXE operand. It also keeps a saturating count of data-hazard freezes.
//
// Parameters
//   DEPTH     tracked stages from EXE onward (0 = EXE, 1 = MEM, DEPTH-1 = WB)
//   NUM_SRC   source operands per instruction
//   REG_W     register address width
//   LOAD_LAT  first entry index from which load data can be forwarded
//   CNT_W     stall counter width
//   SEL_W     clog2(DEPTH), derived
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   forward_en    1 = forwarding enabled
//   id_valid      ID holds a real instruction
//   id_src        ID source registers, source i at [i*REG_W +: REG_W]
//   id_src_used   bit i = source i is read
//   id_wb_en      ID instruction writes back
//   id_mem_r_en   ID instruction is a load
//   id_dest       ID destination register
//   branch_taken  branch resolved taken in EXE
//   mem_stall     memory stage waiting (SRAM busy)
//   freeze        hold PC and IF/ID register
//   flush         clear IF/ID and ID/EXE registers
//   sel_src       EXE operand select per source (0 = register file, k = entry k)
//   stall_cnt     saturating count of data-hazard freeze cycles
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int DEPTH    = 3,
    parameter int NUM_SRC  = 2,
    parameter int REG_W    = 4,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16,
    localparam int SEL_W   = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       forward_en,
    input  logic                       id_valid,
    input  logic [NUM_SRC*REG_W-1:0]   id_src,
    input  logic [NUM_SRC-1:0]         id_src_used,
    input  logic                       id_wb_en,
    input  logic                       id_mem_r_en,
    input  logic [REG_W-1:0]           id_dest,
    input  logic                       branch_taken,
    input  logic                       mem_stall,
    output logic                       freeze,
    output logic                       flush,
    output logic [NUM_SRC*SEL_W-1:0]   sel_src,
    output logic [CNT_W-1:0]           stall_cnt
);

    // Scoreboard: one bit per entry for valid / write-back / load, and the
    // destinations packed side by side (entry k at [k*REG_W +: REG_W]).
    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [DEPTH-1:0]         wb_q, wb_d;
    logic [DEPTH-1:0]         ld_q, ld_d;
    logic [DEPTH*REG_W-1:0]   dest_q, dest_d;

    // Source operands of the instruction currently sitting in entry 0 (EXE).
    logic [NUM_SRC*REG_W-1:0] exe_src_q, exe_src_d;
    logic [NUM_SRC-1:0]       exe_used_q, exe_used_d;

    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [DEPTH-1:0]         id_match [NUM_SRC];
    logic [NUM_SRC-1:0]       young_hit;
    logic [NUM_SRC-1:0]       young_ld;
    logic [SEL_W-1:0]         young_k [NUM_SRC];
    logic [SEL_W-1:0]         fwd_sel [NUM_SRC];
    logic                     data_hazard;
    logic                     hazard;
    logic                     flush_int;
    logic                     freeze_int;

    // Compare every ID source against every scoreboard entry.
    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            id_match[s] = '0;
            for (int k = 0; k < DEPTH; k++) begin
                id_match[s][k] = valid_q[k] & wb_q[k] & id_src_used[s] &
                                 (dest_q[k*REG_W +: REG_W] == id_src[s*REG_W +: REG_W]);
            end
        end
    end

    // Only the youngest matching producer matters: scanning from the oldest
    // entry towards EXE lets the younger hit overwrite the older one, so a
    // younger ALU result shadows an older load to the same register.
    always_comb begin
        young_hit = '0;
        young_ld  = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            young_k[s] = '0;
            for (int k = DEPTH-1; k >= 0; k--) begin
                if (id_match[s][k]) begin
                    young_hit[s] = 1'b1;
                    young_ld[s]  = ld_q[k];
                    young_k[s]   = SEL_W'(k);
                end
            end
        end
    end

    // Without forwarding the consumer waits until its producer reaches WB.
    // With forwarding only a load too young to supply its data stalls; the
    // "+ 2 <=" form keeps LOAD_LAT = 1 from ever firing without a negative
    // bound.
    always_comb begin
        data_hazard = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (young_hit[s]) begin
                if (!forward_en) begin
                    if (int'(young_k[s]) <= DEPTH-2) begin
                        data_hazard = 1'b1;
                    end
                end else if (young_ld[s] && (int'(young_k[s]) + 2 <= LOAD_LAT)) begin
                    data_hazard = 1'b1;
                end
            end
        end
    end

    // A taken branch squashes the stalled consumer anyway, so it overrides
    // the hazard freeze. A memory wait freezes everything, and the flush is
    // deferred until it clears (branch_taken persists because EXE is held).
    always_comb begin
        hazard     = id_valid & data_hazard;
        flush_int  = branch_taken & ~mem_stall;
        freeze_int = mem_stall | (hazard & ~branch_taken);
        freeze     = rst & freeze_int;
        flush      = rst & flush_int;
    end

    // Forwarding select for the EXE operands: the nearest later stage that
    // writes the register wins. Entry 0 is the consumer itself, so the scan
    // starts at entry 1.
    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            fwd_sel[s] = '0;
            for (int k = DEPTH-1; k >= 1; k--) begin
                if (forward_en && exe_used_q[s] && valid_q[k] && wb_q[k] &&
                    (dest_q[k*REG_W +: REG_W] == exe_src_q[s*REG_W +: REG_W])) begin
                    fwd_sel[s] = SEL_W'(k);
                end
            end
        end
    end

    always_comb begin
        sel_src = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            sel_src[s*SEL_W +: SEL_W] = rst ? fwd_sel[s] : '0;
        end
    end

    // Scoreboard advance: everything moves one stage per cycle unless memory
    // is waiting. Entry 0 takes the ID instruction, or a bubble when ID is
    // stalled on a hazard or squashed by a taken branch.
    always_comb begin
        valid_d    = valid_q;
        wb_d       = wb_q;
        ld_d       = ld_q;
        dest_d     = dest_q;
        exe_src_d  = exe_src_q;
        exe_used_d = exe_used_q;
        if (!mem_stall) begin
            valid_d = {valid_q[DEPTH-2:0], 1'b0};
            wb_d    = {wb_q[DEPTH-2:0], 1'b0};
            ld_d    = {ld_q[DEPTH-2:0], 1'b0};
            dest_d  = {dest_q[(DEPTH-1)*REG_W-1:0], {REG_W{1'b0}}};
            if (hazard || flush_int) begin
                exe_src_d  = '0;
                exe_used_d = '0;
            end else begin
                valid_d[0]             = id_valid;
                wb_d[0]                = id_wb_en;
                ld_d[0]                = id_mem_r_en;
                dest_d[REG_W-1:0]      = id_dest;
                exe_src_d              = id_src;
                exe_used_d             = id_src_used;
            end
        end
    end

    // Count only freeze cycles that are caused by a data hazard and actually
    // cost a cycle (not hidden by a branch or a memory wait).
    always_comb begin
        cnt_d = cnt_q;
        if (hazard && !branch_taken && !mem_stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= '0;
            wb_q       <= '0;
            ld_q       <= '0;
            dest_q     <= '0;
            exe_src_q  <= '0;
            exe_used_q <= '0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            wb_q       <= wb_d;
            ld_q       <= ld_d;
            dest_q     <= dest_d;
            exe_src_q  <= exe_src_d;
            exe_used_q <= exe_used_d;
            cnt_q      <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Drives two controllers from one set of inputs: unit 0 with the default
// parameters and unit 1 with DEPTH = 4, LOAD_LAT = 3, CNT_W = 4. Each
// directed cycle may queue hand-computed expectations for either unit; a
// separate negedge monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        forward_en = 1'b0;
    logic        id_valid = 1'b0;
    logic [7:0]  id_src = '0;
    logic [1:0]  id_src_used = '0;
    logic        id_wb_en = 1'b0;
    logic        id_mem_r_en = 1'b0;
    logic [3:0]  id_dest = '0;
    logic        branch_taken = 1'b0;
    logic        mem_stall = 1'b0;

    logic        freeze_a, flush_a, freeze_b, flush_b;
    logic [3:0]  sel_a, sel_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    pipeline_hazard_ctrl dut_a (
        .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
        .id_src(id_src), .id_src_used(id_src_used), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .branch_taken(branch_taken),
        .mem_stall(mem_stall), .freeze(freeze_a), .flush(flush_a),
        .sel_src(sel_a), .stall_cnt(cnt_a)
    );

    pipeline_hazard_ctrl #(.DEPTH(4), .LOAD_LAT(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
        .id_src(id_src), .id_src_used(id_src_used), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .branch_taken(branch_taken),
        .mem_stall(mem_stall), .freeze(freeze_b), .flush(flush_b),
        .sel_src(sel_b), .stall_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        int           unit;
        logic [127:0] name;
        logic         freeze;
        logic         flush;
        logic [3:0]   sel;
        logic [15:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    // One pipeline cycle of inputs, applied just after the rising edge.
    // Leaving reset is implicit: every new cycle releases rst.
    task automatic applyStimulus(input logic fwd, input logic vld,
                                 input logic [3:0] s0, input logic [3:0] s1,
                                 input logic [1:0] used, input logic wb,
                                 input logic ld, input logic [3:0] dest,
                                 input logic br, input logic ms);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        forward_en   = fwd;
        id_valid     = vld;
        id_src       = {s1, s0};
        id_src_used  = used;
        id_wb_en     = wb;
        id_mem_r_en  = ld;
        id_dest      = dest;
        branch_taken = br;
        mem_stall    = ms;
    endtask

    // Queue the expected outputs of one unit for the current cycle.
    task automatic checkOutput(input int unit, input logic [127:0] name,
                               input logic fr, input logic fl,
                               input logic [3:0] sel, input logic [15:0] cnt);
        exp_t e;
        e.cyc    = cyc;
        e.unit   = unit;
        e.name   = name;
        e.freeze = fr;
        e.flush  = fl;
        e.sel    = sel;
        e.cnt    = cnt;
        exp_q.push_back(e);
    endtask

    // Reset held for a whole cycle with mem_stall/branch_taken active, so the
    // forced-zero outputs are visible.
    task automatic resetPhase();
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1);
        rst = 1'b0;
        checkOutput(0, "reset", 0, 0, 4'h0, 16'd0);
        checkOutput(1, "reset", 0, 0, 4'h0, 16'd0);
    endtask

    // Monitor: compares queued expectations for this cycle, and checks that
    // no forwarding select ever points at a load younger than LOAD_LAT.
    always @(negedge clk) begin
        exp_t        e;
        logic        g_fr, g_fl;
        logic [3:0]  g_sel;
        logic [15:0] g_cnt;
        int          k;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            tests_run++;
            if (e.unit == 0) begin
                g_fr = freeze_a; g_fl = flush_a; g_sel = sel_a; g_cnt = cnt_a;
            end else begin
                g_fr = freeze_b; g_fl = flush_b; g_sel = sel_b; g_cnt = {12'd0, cnt_b};
            end
            if (e.cyc != cyc || g_fr !== e.freeze || g_fl !== e.flush ||
                g_sel !== e.sel || g_cnt !== e.cnt) begin
                tests_failed++;
                $display("[TB] FAIL %0s unit%0d cyc%0d: got freeze=%b flush=%b sel=%h cnt=%0d, want freeze=%b flush=%b sel=%h cnt=%0d",
                         e.name, e.unit, e.cyc, g_fr, g_fl, g_sel, g_cnt,
                         e.freeze, e.flush, e.sel, e.cnt);
            end
        end
        for (int s = 0; s < 2; s++) begin
            k = int'(sel_a[s*2 +: 2]);
            if (k != 0) begin
                tests_run++;
                if (k < 2 && dut_a.ld_q[k] === 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL early_load_fwd unit0 src%0d: sel=%0d is a load, required sel >= 2", s, k);
                end
            end
            k = int'(sel_b[s*2 +: 2]);
            if (k != 0) begin
                tests_run++;
                if (k < 3 && dut_b.ld_q[k] === 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL early_load_fwd unit1 src%0d: sel=%0d is a load, required sel >= 3", s, k);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // ALU chain with forwarding: no stall, sel 1 then sel 2.
        resetPhase();
        applyStimulus(1, 1, 0, 0, 2'b00, 1, 0, 3, 0, 0);
        checkOutput(0, "A_c0", 0, 0, 4'h0, 16'd0);
        applyStimulus(1, 1, 3, 0, 2'b01, 1, 0, 7, 0, 0);
        checkOutput(0, "A_nostall", 0, 0, 4'h0, 16'd0);
        applyStimulus(1, 1, 0, 3, 2'b10, 1, 0, 8, 0, 0);
        checkOutput(0, "A_sel1", 0, 0, 4'h1, 16'd0);
        applyStimulus(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        checkOutput(0, "A_sel2", 0, 0, 4'h8, 16'd0);

        // Load-use: 1 freeze on unit 0 (sel 2), 2 freezes on unit 1 (sel 3).
        resetPhase();
        applyStimulus(1, 1, 0, 0, 2'b00, 1, 1, 2, 0, 0);
        checkOutput(0, "B_c0", 0, 0, 4'h0, 16'd0);
        checkOutput(1, "B_c0", 0, 0, 4'h0, 16'd0);
        applyStimulus(1, 1, 2, 0, 2'b01, 1, 0, 9, 0, 0);
        checkOutput(0, "B_lu_frz", 1, 0, 4'h0, 16'd0);
        checkOutput(1, "B_lu_frz", 1, 0, 4'h0, 16'd0);
        applyStimulus(1, 1, 2, 0, 2'b01, 1, 0, 9, 0, 0);
        checkOutput(0, "B_lu_go", 0, 0, 4'h0, 16'd1);
        checkOutput(1, "B_ll3_frz2", 1, 0, 4'h0, 16'd1);
        applyStimulus(1, 1, 2, 0, 2'b01, 1, 0, 9, 0, 0);
        checkOutput(0, "B_sel2", 0, 0, 4'h2, 16'd1);
        checkOutput(1, "B_ll3_go", 0, 0, 4'h0, 16'd2);
        applyStimulus(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        checkOutput(0, "B_cnt", 0, 0, 4'h0, 16'd1);
        checkOutput(1, "B_sel3", 0, 0, 4'h3, 16'd2);

        // No forwarding: distance 1 stalls twice, distance 3 does not stall.
        resetPhase();
        applyStimulus(0, 1, 0, 0, 2'b00, 1, 0, 5, 0, 0);
        checkOutput(0, "C_c0", 0, 0, 4'h0, 16'd0);
        applyStimulus(0, 1, 5, 0, 2'b01, 1, 0, 10, 0, 0);
        checkOutput(0, "C_frz1", 1, 0, 4'h0, 16'd0);
        applyStimulus(0, 1, 5, 0, 2'b01, 1, 0, 10, 0, 0);
        checkOutput(0, "C_frz2", 1, 0, 4'h0, 16'd1);
        applyStimulus(0, 1, 5, 0, 2'b01, 1, 0, 10, 0, 0);
        checkOutput(0, "C_go", 0, 0, 4'h0, 16'd2);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 2'b00, 1, 0, 5, 0, 0);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 5, 0, 2'b01, 1, 0, 10, 0, 0);
        checkOutput(0, "C_dist3", 0, 0, 4'h0, 16'd2);

        // Forwarding switched off while a forwardable consumer is in EXE.
        resetPhase();
        applyStimulus(1, 1, 0, 0, 2'b00, 1, 0, 5, 0, 0);
        applyStimulus(1, 1, 5, 0, 2'b01, 1, 0, 10, 0, 0);
        checkOutput(0, "C2_fwd_nostall", 0, 0, 4'h0, 16'd0);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        checkOutput(0, "C2_fwd_off_sel", 0, 0, 4'h0, 16'd0);

        // Younger ALU write shadows an older load (unit 1, LOAD_LAT = 3).
        resetPhase();
        applyStimulus(1, 1, 0, 0, 2'b00, 1, 1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 2'b00, 1, 0, 1, 0, 0);
        checkOutput(1, "D_c1", 0, 0, 4'h0, 16'd0);
        applyStimulus(1, 1, 1, 0, 2'b01, 1, 0, 11, 0, 0);
        checkOutput(1, "D_shadow", 0, 0, 4'h0, 16'd0);
        applyStimulus(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        checkOutput(1, "D_sel1", 0, 0, 4'h1, 16'd0);

        // Memory wait with a taken branch, then hazard with a taken branch.
        resetPhase();
        applyStimulus(1, 1, 0, 0, 2'b00, 1, 0, 6, 0, 0);
        applyStimulus(1, 1, 6, 0, 2'b01, 1, 0, 13, 0, 0);
        checkOutput(0, "E_c1", 0, 0, 4'h0, 16'd0);
        applyStimulus(1, 1, 6, 0, 2'b01, 1, 0, 12, 1, 1);
        checkOutput(0, "E_ms_br", 1, 0, 4'h1, 16'd0);
        applyStimulus(1, 1, 6, 0, 2'b01, 1, 0, 12, 1, 1);
        checkOutput(0, "E_ms_hold", 1, 0, 4'h1, 16'd0);
        applyStimulus(1, 1, 6, 0, 2'b01, 1, 0, 12, 1, 0);
        checkOutput(0, "E_rel_flush", 0, 1, 4'h1, 16'd0);
        applyStimulus(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        checkOutput(0, "E_bubble", 0, 0, 4'h0, 16'd0);
        applyStimulus(1, 1, 0, 0, 2'b00, 1, 1, 2, 0, 0);
        applyStimulus(1, 1, 2, 0, 2'b01, 1, 0, 9, 1, 0);
        checkOutput(0, "E_hz_br", 0, 1, 4'h0, 16'd0);
        applyStimulus(1, 1, 2, 0, 2'b01, 1, 0, 9, 0, 0);
        checkOutput(0, "E_after_br", 0, 0, 4'h0, 16'd0);

        // Self-dependent instruction without forwarding on unit 1: 3 of every
        // 4 cycles freeze, so the 4-bit counter reaches 14 and saturates.
        resetPhase();
        for (int n = 0; n < 25; n++) begin
            applyStimulus(0, 1, 5, 0, 2'b01, 1, 0, 5, 0, 0);
            if (n == 19) checkOutput(1, "F_cnt14", 1, 0, 4'h0, 16'd14);
            if (n == 20) checkOutput(1, "F_cnt15", 0, 0, 4'h0, 16'd15);
            if (n == 23) checkOutput(1, "F_sat", 1, 0, 4'h0, 16'd15);
            if (n == 24) checkOutput(1, "F_sat_hold", 0, 0, 4'h0, 16'd15);
        end
        applyStimulus(0, 1, 5, 0, 2'b01, 1, 0, 5, 1, 1);
        rst = 1'b0;
        checkOutput(1, "F_rst_now", 0, 0, 4'h0, 16'd0);
        checkOutput(0, "F_rst_now", 0, 0, 4'h0, 16'd0);
        applyStimulus(0, 1, 5, 0, 2'b01, 1, 0, 5, 0, 0);
        checkOutput(1, "F_post_rst", 0, 0, 4'h0, 16'd0);
        applyStimulus(0, 1, 5, 0, 2'b01, 1, 0, 5, 0, 0);
        checkOutput(1, "F_post_rst2", 1, 0, 4'h0, 16'd0);

        repeat (2) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain: got %0d unchecked expectations, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard and forwarding controller for the ARM pipeline, replacing the separate two-stage hazard detector and forwarding unit. It keeps a shift-register scoreboard of in-flight destinations from EXE through WB (depth configurable), generates freeze/flush for IF/ID, and produces per-source forwarding selects for the EXE operand muxes. Compared with the current units it adds a configurable post-EXE depth, configurable load latency, N source operands, memory-wait stalls and a saturating data-hazard stall counter.

## Interface
- DEPTH, 3: tracked stages from EXE onward (entry 0 = EXE, 1 = MEM, DEPTH-1 = WB); legal range 3..8
- NUM_SRC, 2: source operands per instruction
- REG_W, 4: register address width
- LOAD_LAT, 2: first entry index at which load data can be forwarded; legal range 1..DEPTH-1
- CNT_W, 16: stall counter width
- SEL_W = clog2(DEPTH), derived (not overridable)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- forward_en  in  1  1 = forwarding enabled
- id_valid  in  1  ID holds a real instruction
- id_src  in  NUM_SRC*REG_W  ID source registers, source i at [i*REG_W +: REG_W]
- id_src_used  in  NUM_SRC  bit i = source i is read
- id_wb_en, id_mem_r_en  in  1 each  ID instruction writes back / is a load
- id_dest  in  REG_W  ID destination
- branch_taken  in  1  branch resolved taken in EXE
- mem_stall  in  1  memory stage waiting (SRAM busy)
- freeze  out  1  hold PC and IF/ID register
- flush  out  1  clear IF/ID and ID/EXE registers
- sel_src  out  NUM_SRC*SEL_W  EXE operand select per source: 0 = register-file value, k = forward from entry k
- stall_cnt  out  CNT_W  saturating count of data-hazard freeze cycles

## Operation
- Scoreboard entry e[k] = {valid, wb_en, mem_r_en, dest}. A separate EXE source register holds {src, src_used} of the instruction in entry 0.
- Match(k, s): e[k].valid & e[k].wb_en & id_src_used[s] & e[k].dest == id_src[s]. The youngest matching entry (smallest k) alone decides.
- Data hazard, forward_en = 0: any match in entries 0..DEPTH-2.
- Data hazard, forward_en = 1: the youngest match is a load (mem_r_en) at an entry k <= LOAD_LAT-2.
  - With LOAD_LAT = 1 this condition never fires.
  - A younger ALU match shadows an older load, so no stall is raised.
- hazard = id_valid & data hazard.
- freeze = mem_stall | (hazard & ~branch_taken).
- flush = branch_taken & ~mem_stall.
- Forwarding for each EXE source s:
  - sel = the smallest k in 1..DEPTH-1 where entry k matches the EXE source.
  - sel = 0 if there is no match, if forward_en = 0, or if the source is unused.
  - A load match at k < LOAD_LAT cannot happen (the stall prevents it) and is asserted in the bench.
- Scoreboard update on each clock edge:
  - mem_stall = 1: all entries and the EXE source register hold.
  - Otherwise: e[k] <= e[k-1] for k >= 1.
  - e[0] <= ID fields with valid = id_valid, unless hazard or flush, in which case e[0] <= bubble (valid = 0).
  - The EXE source register loads on the same rule; a bubble clears src_used.
- stall_cnt increments by 1 on each cycle with hazard & ~branch_taken & ~mem_stall, and saturates at 2^CNT_W-1.
- Entry dest equal to register 15 gets no special treatment.

## Timing
- freeze, flush and sel_src are combinational from the current scoreboard and inputs, in the same cycle. Scoreboard and counter update on the rising edge.
- Load-use with defaults: consumer in ID while the load is in EXE gives 1 freeze cycle. The consumer then reaches EXE with the load in WB, so sel = 2.
- Back-to-back ALU dependency with forwarding: 0 stall cycles, sel = 1.
- Without forwarding: a consumer immediately behind its producer stalls DEPTH-1 cycles (2 with defaults).
- Simultaneous branch_taken and hazard: flush wins, freeze = 0, and e[0] becomes a bubble.
- Simultaneous mem_stall and branch_taken: freeze = 1 and flush = 0. The flush is issued on the first cycle after mem_stall drops, because EXE is held and branch_taken persists.
- Reset (rst = 0, asynchronous):
  - All entries invalid, EXE source register cleared, stall_cnt = 0.
  - Outputs forced to freeze = 0, flush = 0, sel_src = 0 while rst = 0.
  - The first edge after release behaves as an empty pipeline.

## Test plan
- Forwarding on, ALU writes R3 then the next instruction reads R3 -> no freeze; next cycle sel_src[0] = 1; one cycle later the instruction after it reading R3 gets sel = 2.
- Forwarding on, load R2 followed by a consumer of R2 -> freeze = 1 for exactly 1 cycle, stall_cnt = 1; consumer in EXE sees sel = 2. Repeat with LOAD_LAT = 3, DEPTH = 4 -> 2 freeze cycles, sel = 3.
- Forwarding off, ALU writes R5, consumer reads R5 at distance 1 -> 2 freeze cycles, sel always 0; at distance 3 -> 0 stalls.
- Load R1 at entry 1 and ALU writing R1 at entry 0, LOAD_LAT = 3 -> no stall (youngest match shadows the load); consumer then forwards from entry 1.
- Hazard, branch_taken and mem_stall in combinations -> mem_stall gives freeze = 1 and flush = 0 with the scoreboard frozen; on release flush = 1 and e[0] is a bubble; hazard with branch gives freeze = 0.
- Force stall_cnt to 2^CNT_W-2 (CNT_W = 4) with 3 hazard cycles -> saturates at 15. Assert rst mid-stall -> all outputs 0 immediately and the counter clears.
